// File: rtl/loader_pkg.sv
// Shared types and constants for the byte-stream program loader.
package loader_pkg;
  localparam int BYTE_W     = 8;
  localparam int DEFAULT_AW = 8;
  localparam int DEFAULT_DW = 16;

  typedef enum logic [3:0] {
    IDLE, LEN_LO, LEN_HI, DATA_LO, DATA_HI, WRITE, CSUM_LO, CSUM_HI, DONE, ERR
  } state_t;

  // States in which the loader is willing to take a byte.
  function automatic logic is_rx_state(input state_t s);
    return (s == LEN_LO)  || (s == LEN_HI)  || (s == DATA_LO) ||
           (s == DATA_HI) || (s == CSUM_LO) || (s == CSUM_HI);
  endfunction
endpackage

// File: rtl/prog_loader_byte_pair_asm.sv
// Low/high byte latch: holds the low byte and completes the word when the high byte arrives.
module byte_pair_asm
  import loader_pkg::*;
#(
  parameter int DW = DEFAULT_DW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] byte_i,
  input  logic              accept_i,
  input  logic              sel_hi_i,
  output logic [DW-1:0]     word_o,
  output logic              word_ok_o
);
  logic [BYTE_W-1:0] lo_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lo_q <= '0;
    end else if (accept_i && !sel_hi_i) begin
      lo_q <= byte_i;
    end
  end

  // Word is valid in the same cycle the high byte is accepted.
  assign word_o    = DW'({byte_i, lo_q});
  assign word_ok_o = accept_i && sel_hi_i;
endmodule

// File: rtl/prog_loader.sv
// Program loader: receives LEN / data / CSUM frame over a byte handshake and writes words to RAM.
module prog_loader
  import loader_pkg::*;
#(
  parameter int AW = DEFAULT_AW,
  parameter int DW = DEFAULT_DW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [BYTE_W-1:0] byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic [AW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_din,
  output logic              mem_write,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);
  localparam logic [DW:0] MAX_LEN = (DW+1)'(2 ** AW);

  state_t        state_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] din_q;
  logic [DW-1:0] len_q;
  logic [DW-1:0] csum_q;
  logic [AW:0]   count_q;
  logic [AW:0]   count_inc;
  logic          accept;
  logic          sel_hi;
  logic [DW-1:0] word;
  logic          word_ok;

  assign accept    = byte_valid && byte_ready;
  assign sel_hi    = (state_q == LEN_HI) || (state_q == DATA_HI) || (state_q == CSUM_HI);
  assign count_inc = count_q + 1'b1;

  byte_pair_asm #(.DW(DW)) u_asm (
    .clk       (clk),
    .rst       (rst),
    .byte_i    (byte_in),
    .accept_i  (accept),
    .sel_hi_i  (sel_hi),
    .word_o    (word),
    .word_ok_o (word_ok)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      din_q   <= '0;
      len_q   <= '0;
      csum_q  <= '0;
      count_q <= '0;
    end else begin
      case (state_q)
        IDLE, DONE, ERR: begin
          if (start) begin
            state_q <= LEN_LO;
            addr_q  <= '0;
            csum_q  <= '0;
            count_q <= '0;
          end
        end
        LEN_LO:  if (accept) state_q <= LEN_HI;
        LEN_HI: begin
          if (word_ok) begin
            len_q <= word;
            if ({1'b0, word} > MAX_LEN)  state_q <= ERR;
            else if (word == '0)         state_q <= CSUM_LO;
            else                         state_q <= DATA_LO;
          end
        end
        DATA_LO: if (accept) state_q <= DATA_HI;
        DATA_HI: begin
          if (word_ok) begin
            din_q   <= word;
            csum_q  <= csum_q ^ word;
            state_q <= WRITE;
          end
        end
        WRITE: begin
          // For a full 2^AW frame the address wraps to 0 here; the next state is CSUM_LO.
          addr_q  <= addr_q + 1'b1;
          count_q <= count_inc;
          state_q <= (DW'(count_inc) == len_q) ? CSUM_LO : DATA_LO;
        end
        CSUM_LO: if (accept) state_q <= CSUM_HI;
        CSUM_HI: begin
          if (word_ok) state_q <= (word == csum_q) ? DONE : ERR;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign byte_ready = is_rx_state(state_q);
  assign mem_addr   = addr_q;
  assign mem_din    = din_q;
  assign mem_write  = (state_q == WRITE);
  assign cpu_hold   = (state_q != DONE);
  assign done       = (state_q == DONE);
  assign err        = (state_q == ERR);
endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Byte-stream program loader. It is the writer side of the instruction/data RAM that the CPU's PC_RAM block reads.
- Receives a framed program over a byte valid/ready handshake: a length header, then data words, then a checksum word.
- Writes each assembled 16-bit word into RAM from address 0 upward.
- Holds the CPU in reset (cpu_hold) until a frame is loaded and its checksum verifies.

Parameters:
- AW, 8, RAM address width; matches the 8-bit PC.
- DW, 16, RAM word width; matches the instruction register width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset; driven directly from a KEY).
- start  in  1  begin a new load; sampled only in IDLE, DONE or ERR.
- byte_in  in  8  incoming byte.
- byte_valid  in  1  byte_in is valid this cycle.
- byte_ready  out  1  loader accepts a byte this cycle; transfer occurs when byte_valid && byte_ready.
- mem_addr  out  AW  RAM write address.
- mem_din  out  DW  RAM write data.
- mem_write  out  1  RAM write strobe, one cycle per word.
- cpu_hold  out  1  OR this into the CPU reset; 1 keeps the CPU in reset.
- done  out  1  frame loaded and checksum matched.
- err  out  1  frame rejected (length overflow or checksum mismatch).

Behaviour:
- Reset values: state=IDLE, byte_ready=0, mem_addr=0, mem_din=0, mem_write=0, cpu_hold=1, done=0, err=0. Internal count and checksum are 0.
- Byte order: each word is sent low byte first, then high byte.
- Frame format: LEN (1 word, N), then N data words, then CSUM (1 word). CSUM is the XOR of all N data words.
- States:
  - IDLE: byte_ready=0. On start -> LEN_LO; clear mem_addr, count, checksum, done and err; cpu_hold=1.
  - LEN_LO: byte_ready=1. On accept, latch the low byte -> LEN_HI.
  - LEN_HI: byte_ready=1. On accept, form N.
    - N > 2^AW -> ERR.
    - N = 0 -> CSUM_LO.
    - Otherwise -> DATA_LO.
  - DATA_LO: byte_ready=1. On accept, latch the low byte -> DATA_HI.
  - DATA_HI: byte_ready=1. On accept, mem_din <= {byte_in, low}, XOR the word into checksum -> WRITE.
  - WRITE: byte_ready=0, mem_write=1 for exactly one cycle at the current mem_addr. Next cycle: mem_addr increments, count increments.
    - count+1 == N -> CSUM_LO.
    - Otherwise -> DATA_LO.
  - CSUM_LO / CSUM_HI: byte_ready=1; assemble the received word.
    - Received word == checksum -> DONE.
    - Otherwise -> ERR.
  - DONE: done=1, cpu_hold=0, byte_ready=0. On start -> LEN_LO, with cpu_hold=1 and done=0 in the same transition.
  - ERR: err=1, cpu_hold=1, byte_ready=0. On start -> LEN_LO with err=0.
- Latency: mem_write asserts in the cycle after the high data byte is accepted. Minimum 3 cycles per word at a continuous stream (LO, HI, WRITE).
- Stalls: byte_valid may drop at any time; the state holds with no timeout.
- start outside IDLE/DONE/ERR is ignored; no restart mid-frame.
- mem_addr wrap: for N = 2^AW the last write goes to address 2^AW-1. mem_addr then wraps to 0, which is harmless because the next state is CSUM_LO.
- Reset mid-frame returns the block to IDLE with cpu_hold=1. Partially written RAM contents are not cleared.
- mem_write is never asserted outside WRITE. Only one write is issued per data word.

Decomposition:
- Shared package loader_pkg holds:
  - state enum: IDLE, LEN_LO, LEN_HI, DATA_LO, DATA_HI, WRITE, CSUM_LO, CSUM_HI, DONE, ERR;
  - BYTE_W = 8;
  - DEFAULT_AW = 8, DEFAULT_DW = 16.
- One sub-module, byte_pair_asm:
  - function: low/high byte latch, emitting a 16-bit word plus a one-cycle word_ok pulse;
  - reuse: shared by the LEN, DATA and CSUM phases;
  - ownership: the FSM keeps count, checksum, address and outputs.

Test Plan:
- Reset check: hold rst=0 while start=1 and byte_valid=1, then release. Required: cpu_hold=1, done=0, err=0, mem_write=0, byte_ready=0, mem_addr=0 until start.
- Three-word load: start, then bytes 03 00 | 01 A0 | 02 B0 | 04 C0 | CSUM 07 D0. Required: writes (0,A001), (1,B002), (2,C004); done=1; cpu_hold=0.
- Checksum mismatch: same frame with CSUM 08 D0. Required: the three writes occur, then err=1, done=0, cpu_hold=1. A following start clears err and byte_ready returns to 1.
- Length edge cases:
  - N=0 with CSUM 0000: required done=1 with no mem_write.
  - N=0x0101: required err=1 right after the second length byte, and no writes.
- Stalls and mid-frame reset: random byte_valid gaps of 0-5 cycles with N=256 all-FFFF data and CSUM 0000. Required: 256 writes, addresses 00..FF in order, done=1. Then repeat the frame, assert rst mid-DATA_HI, and require an immediate return to IDLE with cpu_hold=1.
- Restart from DONE: after a good load, pulse start. Required: cpu_hold rises in the same cycle the state leaves DONE, done falls, mem_addr=0, and a second frame loads correctly.
